alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised multi-cycle successor of the combinational ALU.
//  - Ops: add/sub in one cycle; multiply and divide as iterative shift-add / restoring-divide engines.
//  - Control: start/busy/done handshake, registered result, registered flags (negativo, cero, acarreo, desbordamiento).
//  - Sits between the register file and the writeback stage; the control FSM stalls on busy.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (min 4)
// PORTS
//  clk             in   1      single clock, rising edge
//  rst             in   1      asynchronous reset, active-high
//  start           in   1      request; accepted when busy=0
//  opCode          in   2      00 ADD, 01 MUL, 10 DIV (unsigned), 11 SUB
//  a, b            in   WIDTH  operands, sampled on accept
//  ci              in   1      carry-in for ADD (ignored for other ops)
//  busy            out  1      high from the accept cycle+1 until done
//  done            out  1      one-cycle pulse; out/flags valid from this cycle on
//  out             out  WIDTH  result, held until the next accepted start
//  negativo        out  1      out[WIDTH-1]
//  cero            out  1      out == 0
//  acarreo         out  1      ADD carry-out; SUB no-borrow (a>=b); MUL product[2W-1:W]!=0; DIV 0
//  desbordamiento  out  1      ADD/SUB signed overflow; MUL product[2W-1:W]!=0; DIV b==0
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-operation): state=IDLE; busy=done=0; out=0; all flags=0;
//    iteration counter and internal accumulators cleared; the aborted op produces no done.
//  - FSM states IDLE, CALC, DONE.
//    - IDLE/DONE --start--> CALC (MUL, DIV with b!=0) or DONE (ADD, SUB, DIV with b==0).
//    - CALC --count==WIDTH-1--> DONE.
//    - DONE lasts 1 cycle, then IDLE unless start is high in that cycle (back-to-back accept).
//  - Latency, from accept edge N: done high after edge N+1 for ADD/SUB/DIV-by-0, after edge N+WIDTH+1 for MUL/DIV.
//  - busy=1 only in CALC. start is ignored while busy=1; opCode/a/b/ci may change freely then.
//  - ADD: {acarreo,out} = a+b+ci. SUB: out = a-b (mod 2^WIDTH), ci ignored.
//  - MUL: unsigned, one partial product per cycle; out = product[WIDTH-1:0]; high half only sets flags.
//  - DIV: unsigned restoring, one quotient bit per cycle, MSB first; out = quotient.
//    - b==0: out = all ones, desbordamiento=1, acarreo=0, no iterations.
//  - out and flags update only on the done cycle; between ops they hold the previous result.
// CONFIGURATION
//  ALU_SEQ_RESTO_EN defined: extra port  resto  out  WIDTH.
//    - Holds the DIV remainder; = a on divide-by-zero; 0 after ADD/SUB/MUL; reset 0.
//    - Updates with out on done.
//  ALU_SEQ_RESTO_EN undefined: no resto port, no remainder register; the divider discards it.
//    All other behaviour is identical.
// TESTING  (WIDTH=8)
//  1 ADD a=7,b=2,ci=0 -> out=9, done 1 cycle after accept, cero=0, acarreo=0, desbordamiento=0.
//    ADD a=FF,b=01 -> out=00, cero=1, acarreo=1, desbordamiento=0.
//  2 MUL a=13,b=3 -> out=39, busy for 8 cycles, done exactly 9 cycles after accept.
//    MUL a=16,b=16 -> out=00, cero=1, acarreo=1, desbordamiento=1.
//  3 DIV a=13,b=3 -> out=4 (resto=1 with macro). DIV a=1,b=2 -> out=0, cero=1.
//    DIV a=5,b=0 -> out=FF, desbordamiento=1, done after 1 cycle (resto=5 with macro).
//  4 SUB a=5,b=5 -> out=0, cero=1, acarreo=1.
//    SUB a=1,b=2 -> out=FF, negativo=1, acarreo=0. SUB a=80,b=01 -> out=7F, desbordamiento=1.
//  5 start pulsed with new operands while MUL busy -> ignored; original product delivered.
//    start held high in the DONE cycle -> next op accepted back-to-back.
//  6 rst asserted mid-DIV (cycle 4 of 8) -> busy=done=out=flags=0 immediately, no done pulse.
//    Subsequent ADD 1+2 -> out=3.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU: one-cycle add/sub, iterative multiply and restoring divide
//
// Purpose: sequential successor of the combinational ALU. It sits between the register
//   file and writeback. The control FSM stalls while busy is high.
//   Optional macro ALU_SEQ_RESTO_EN adds the divide remainder output 'resto'.
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   start          request, accepted when busy=0 (IDLE or DONE state)
//   opCode         00 ADD, 01 MUL, 10 DIV (unsigned), 11 SUB
//   a, b, ci       operands, sampled on accept; ci is used by ADD only
//   busy           high while the iterative engine runs (CALC state)
//   done           one-cycle pulse; out/flags are valid from this cycle on
//   out            result, held until the next result is committed
//   negativo, cero, acarreo, desbordamiento   registered flags
//   resto          (ALU_SEQ_RESTO_EN only) divide remainder
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       opCode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             negativo,
  output logic             cero,
  output logic             acarreo,
`ifdef ALU_SEQ_RESTO_EN
  output logic             desbordamiento,
  output logic [WIDTH-1:0] resto
`else
  output logic             desbordamiento
`endif
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        count;
  logic [1:0]           op_q;
  logic [2*WIDTH-1:0]   p;      // MUL product accumulator
  logic [WIDTH-1:0]     x;      // MUL multiplier (shifts right) / DIV dividend->quotient (shifts left)
  logic [WIDTH-1:0]     y;      // multiplicand / divisor, held for the whole operation
  logic [WIDTH-1:0]     r;      // DIV partial remainder

  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   p_n;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       diff;
  logic                 qbit;
  logic [WIDTH-1:0]     x_n;
  logic [WIDTH-1:0]     r_n;
  logic [WIDTH:0]       sum_add;
  logic [WIDTH:0]       sum_sub;
  logic                 last;
  logic                 go_calc;
  logic                 commit;
  logic [WIDTH-1:0]     fin_out;
  logic                 fin_c;
  logic                 fin_v;
`ifdef ALU_SEQ_RESTO_EN
  logic [WIDTH-1:0]     fin_r;
`endif

  always_comb begin
    // One partial product per cycle, weighted by the current bit position.
    addend  = x[0] ? ({{WIDTH{1'b0}}, y} << count) : '0;
    p_n     = p + addend;

    // Restoring divide step: bring in the next dividend bit, try subtracting the divisor.
    shifted = {r, x[WIDTH-1]};
    diff    = shifted - {1'b0, y};
    qbit    = ~diff[WIDTH];

    if (op_q == OP_MUL) begin
      x_n = x >> 1;
      r_n = r;
    end else begin
      x_n = {x[WIDTH-2:0], qbit};
      r_n = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

    sum_add = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    sum_sub = {1'b0, a} - {1'b0, b};   // top bit is the borrow

    last    = (count == CW'(WIDTH - 1));
    go_calc = (opCode == OP_MUL) || ((opCode == OP_DIV) && (b != '0));
    commit  = (state == CALC) ? last : (start && !go_calc);

    fin_out = '0;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
`ifdef ALU_SEQ_RESTO_EN
    fin_r   = '0;
`endif
    if (state == CALC) begin
      if (op_q == OP_MUL) begin
        fin_out = p_n[WIDTH-1:0];
        fin_c   = |p_n[2*WIDTH-1:WIDTH];
        fin_v   = |p_n[2*WIDTH-1:WIDTH];
      end else begin
        fin_out = x_n;
`ifdef ALU_SEQ_RESTO_EN
        fin_r   = r_n;
`endif
      end
    end else begin
      case (opCode)
        OP_ADD: begin
          fin_out = sum_add[WIDTH-1:0];
          fin_c   = sum_add[WIDTH];
          fin_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
        end
        OP_SUB: begin
          fin_out = sum_sub[WIDTH-1:0];
          fin_c   = ~sum_sub[WIDTH];
          fin_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);
        end
        OP_DIV: begin
          // Only reached with b==0: divide-by-zero short cut, no iterations.
          fin_out = '1;
          fin_v   = 1'b1;
`ifdef ALU_SEQ_RESTO_EN
          fin_r   = a;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      count          <= '0;
      op_q           <= OP_ADD;
      p              <= '0;
      x              <= '0;
      y              <= '0;
      r              <= '0;
      out            <= '0;
      negativo       <= 1'b0;
      cero           <= 1'b0;
      acarreo        <= 1'b0;
      desbordamiento <= 1'b0;
`ifdef ALU_SEQ_RESTO_EN
      resto          <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        CALC: begin
          p     <= p_n;
          x     <= x_n;
          r     <= r_n;
          count <= count + CW'(1);
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept; accepting in DONE gives back-to-back operation.
          if (start) begin
            op_q <= opCode;
            if (go_calc) begin
              state <= CALC;
              busy  <= 1'b1;
              count <= '0;
              p     <= '0;
              x     <= a;
              y     <= b;
              r     <= '0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase

      if (commit) begin
        out            <= fin_out;
        negativo       <= fin_out[WIDTH-1];
        cero           <= ~|fin_out;
        acarreo        <= fin_c;
        desbordamiento <= fin_v;
`ifdef ALU_SEQ_RESTO_EN
        resto          <= fin_r;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (WIDTH=8), directed and random ops
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   opCode = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ci = 1'b0;
  logic         busy, done, negativo, cero, acarreo, desbordamiento;
  logic [W-1:0] out;
`ifdef ALU_SEQ_RESTO_EN
  logic [W-1:0] resto;
`endif

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .opCode(opCode), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .out(out), .negativo(negativo), .cero(cero),
`ifdef ALU_SEQ_RESTO_EN
    .acarreo(acarreo), .desbordamiento(desbordamiento), .resto(resto)
`else
    .acarreo(acarreo), .desbordamiento(desbordamiento)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation's definition.
  task automatic model(input logic [1:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ici, output logic [W-1:0] o, output logic c, output logic v,
                       output logic [W-1:0] rem, output int lat);
    int s, sa, sb, prod;
    sa  = int'($signed(ia));
    sb  = int'($signed(ib));
    rem = '0;
    c   = 1'b0;
    v   = 1'b0;
    lat = 1;
    case (op)
      2'b00: begin
        s = int'(ia) + int'(ib) + int'(ici);
        o = W'(s);
        c = (s > 255);
        v = ((sa + sb + int'(ici)) > 127) || ((sa + sb + int'(ici)) < -128);
      end
      2'b11: begin
        o = W'(int'(ia) - int'(ib));
        c = (ia >= ib);
        v = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      2'b01: begin
        prod = int'(ia) * int'(ib);
        o    = W'(prod);
        c    = (prod > 255);
        v    = (prod > 255);
        lat  = W + 1;
      end
      default: begin
        if (ib == 0) begin
          o   = 8'hFF;
          v   = 1'b1;
          rem = ia;
        end else begin
          o   = ia / ib;
          rem = ia % ib;
          lat = W + 1;
        end
      end
    endcase
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic ici);
    logic [W-1:0] eo, er;
    logic         ec, ev;
    int           lat, cyc, nb;
    model(op, ia, ib, ici, eo, ec, ev, er, lat);
    @(negedge clk);
    opCode = op; a = ia; b = ib; ci = ici; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Operands may change freely once accepted.
    a = W'($urandom); b = W'($urandom); opCode = 2'($urandom); ci = 1'($urandom);
    cyc = 1; nb = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) nb++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".latency"}, cyc, lat);
    check({tag, ".busy_cycles"}, nb, lat - 1);
    check({tag, ".out"}, out, eo);
    check({tag, ".negativo"}, negativo, eo[W-1]);
    check({tag, ".cero"}, cero, (eo == 0));
    check({tag, ".acarreo"}, acarreo, ec);
    check({tag, ".desbordamiento"}, desbordamiento, ev);
`ifdef ALU_SEQ_RESTO_EN
    check({tag, ".resto"}, resto, er);
`endif
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, done, 1'b0);
    check({tag, ".out_held"}, out, eo);
  endtask

  initial begin
    int cyc, seen;
    logic [1:0] rop;
    logic [W-1:0] ra, rb;

    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", busy, 1'b0);
    check("reset.done", done, 1'b0);
    check("reset.out", out, 8'h00);
    check("reset.flags", {negativo, cero, acarreo, desbordamiento}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_7_2", 2'b00, 8'h07, 8'h02, 1'b0);
    check("add_7_2.const", out, 8'h09);
    run_op("add_ff_01", 2'b00, 8'hFF, 8'h01, 1'b0);
    check("add_ff_01.const", {out, cero, acarreo}, {8'h00, 1'b1, 1'b1});
    run_op("add_ci", 2'b00, 8'h7F, 8'h00, 1'b1);
    run_op("mul_13_3", 2'b01, 8'd13, 8'd3, 1'b0);
    check("mul_13_3.const", out, 8'd39);
    run_op("mul_16_16", 2'b01, 8'd16, 8'd16, 1'b0);
    run_op("div_13_3", 2'b10, 8'd13, 8'd3, 1'b0);
    check("div_13_3.const", out, 8'd4);
    run_op("div_1_2", 2'b10, 8'd1, 8'd2, 1'b0);
    run_op("div_5_0", 2'b10, 8'd5, 8'd0, 1'b0);
    run_op("div_ff_1", 2'b10, 8'hFF, 8'h01, 1'b0);
    run_op("sub_5_5", 2'b11, 8'd5, 8'd5, 1'b1);
    run_op("sub_1_2", 2'b11, 8'd1, 8'd2, 1'b0);
    check("sub_1_2.const", out, 8'hFF);
    run_op("sub_80_01", 2'b11, 8'h80, 8'h01, 1'b0);
    check("sub_80_01.const", {out, desbordamiento}, {8'h7F, 1'b1});

    // start pulsed with new operands while MUL is busy must be ignored
    @(negedge clk);
    opCode = 2'b01; a = 8'd13; b = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    opCode = 2'b00; a = 8'd1; b = 8'd1;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 4) start = 1'b0;
    end
    check("ignore.latency", cyc, W + 1);
    check("ignore.out", out, 8'd39);
    @(posedge clk); #1;
    check("ignore.no_extra_done", done, 1'b0);

    // start held high in the DONE cycle: back-to-back accept
    @(negedge clk);
    opCode = 2'b00; a = 8'd7; b = 8'd2; ci = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    check("b2b.first_done", done, 1'b1);
    check("b2b.first_out", out, 8'd9);
    opCode = 2'b11; a = 8'd5; b = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b.second_done", done, 1'b1);
    check("b2b.second_out", {out, acarreo}, {8'd2, 1'b1});
    @(posedge clk); #1;
    check("b2b.idle", done, 1'b0);

    // reset in the middle of a divide
    @(negedge clk);
    opCode = 2'b10; a = 8'd13; b = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid.busy", busy, 1'b0);
    check("rstmid.done", done, 1'b0);
    check("rstmid.out", out, 8'h00);
    check("rstmid.flags", {negativo, cero, acarreo, desbordamiento}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("rstmid.no_done", seen, 0);
    run_op("post_rst_add", 2'b00, 8'd1, 8'd2, 1'b0);
    check("post_rst_add.const", out, 8'd3);

    // random operations against the model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
      run_op($sformatf("rnd%0d", i), rop, ra, rb, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
